// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the multicycle MIPS controller.
//   - opcode and funct field encodings
//   - ALU function codes (F) driven onto the datapath ALU
//   - aluop_t: request from the FSM to the ALU decoder
//   - state_t: controller FSM states
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_NONE,
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/mips_mc_controller_aludec.sv
// mc_aludec: combinational ALU decoder.
//   aluop          in  requested operation class from the FSM
//   funct          in  instr[5:0], used only when aluop = ALUOP_FUNCT
//   alucontrol     out ALU function code F (000 when no ALU op is requested)
//   illegal_funct  out funct not supported (valid only for ALUOP_FUNCT)
module mc_aludec
    import mips_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol,
    output logic        illegal_funct
);

    always_comb begin
        alucontrol    = '0;
        illegal_funct = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: begin
                        // Unsupported funct still presents an add so the ALU sees a defined code.
                        alucontrol    = ALU_ADD;
                        illegal_funct = 1'b1;
                    end
                endcase
            end
            default: alucontrol = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: Moore FSM control unit for a multicycle MIPS datapath.
//   clk, reset      rising-edge clock, synchronous active-low reset
//   op, funct       instruction fields from the instruction register
//   zero            ALU zero flag (branch resolution)
//   pcen .. pcsrc   datapath enables and mux selects
//   alucontrol      ALU function code F
//   illegal         sticky flag, set on an unsupported op/funct, cleared by reset
// BNE_EN selects whether opcode 0x05 (bne) is decoded or treated as illegal.
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter bit BNE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    aluop_t aluop;
    logic   illegal_funct;

    mc_aludec u_aludec (
        .aluop         (aluop),
        .funct         (funct),
        .alucontrol    (alucontrol),
        .illegal_funct (illegal_funct)
    );

    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        aluop     = ALUOP_NONE;
        pcen      = 1'b0;
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                aluop   = ALUOP_ADD;
                irwrite = 1'b1;
                pcen    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                aluop   = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_BNE: begin
                        if (BNE_EN) begin
                            state_d = S_BRANCH;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_ADD;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                // Bad funct skips the writeback so no register is corrupted.
                if (illegal_funct) begin
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                pcen    = (op == OP_BNE) ? ~zero : zero;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset aborts the current step: no architectural write may leak out.
        if (!reset) begin
            pcen     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: directed scenarios followed by
// random instruction streams, each compared cycle by cycle against a per-
// instruction list of expected control words built from the instruction class.
module tb_mips_mc_controller;

    localparam bit TB_BNE_EN = 1'b1;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        model_illegal = 1'b0;

    mips_mc_controller #(.BNE_EN(TB_BNE_EN)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ctl_t ctl(input logic p, input logic io, input logic mw, input logic irw,
                                 input logic rd, input logic m2r, input logic rw, input logic asa,
                                 input logic [1:0] asb, input logic [1:0] pcs, input logic [2:0] alu);
        ctl_t c;
        c = {p, io, mw, irw, rd, m2r, rw, asa, asb, pcs, alu};
        return c;
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, alucontrol};
        return c;
    endfunction

    // {supported, F} for an R-type funct field.
    function automatic logic [3:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'h20:   return {1'b1, 3'b010};
            6'h22:   return {1'b1, 3'b110};
            6'h24:   return {1'b1, 3'b000};
            6'h25:   return {1'b1, 3'b001};
            6'h2a:   return {1'b1, 3'b111};
            default: return {1'b0, 3'b010};
        endcase
    endfunction

    function automatic bit op_supported(input logic [5:0] o);
        return (o inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02}) ||
               (o == 6'h05 && TB_BNE_EN);
    endfunction

    // Runs one instruction starting just after the edge that entered FETCH.
    // abort_at >= 0 pulls reset low during that step of the instruction.
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int abort_at);
        ctl_t       exp_q[$];
        ctl_t       e;
        logic [3:0] ra;
        logic       bad;
        op = o; funct = f; zero = z;
        ra  = rtype_alu(f);
        bad = !op_supported(o) || (o == 6'h00 && !ra[3]);

        exp_q.push_back(ctl(1,0,0,1,0,0,0,0,2'b01,2'b00,3'b010));
        exp_q.push_back(ctl(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010));
        if (op_supported(o)) begin
            case (o)
                6'h23: begin
                    exp_q.push_back(ctl(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
                    exp_q.push_back(ctl(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000));
                    exp_q.push_back(ctl(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000));
                end
                6'h2b: begin
                    exp_q.push_back(ctl(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
                    exp_q.push_back(ctl(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000));
                end
                6'h00: begin
                    exp_q.push_back(ctl(0,0,0,0,0,0,0,1,2'b00,2'b00,ra[2:0]));
                    if (ra[3]) exp_q.push_back(ctl(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000));
                end
                6'h04: exp_q.push_back(ctl(z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110));
                6'h05: exp_q.push_back(ctl(~z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110));
                6'h08: begin
                    exp_q.push_back(ctl(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
                    exp_q.push_back(ctl(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000));
                end
                default: exp_q.push_back(ctl(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b000));
            endcase
        end

        for (int k = 0; k < exp_q.size(); k++) begin
            e = exp_q[k];
            if (k == abort_at) begin
                reset = 1'b0;
                e.pcen = 1'b0; e.memwrite = 1'b0; e.irwrite = 1'b0; e.regwrite = 1'b0;
            end
            @(negedge clk);
            check_eq($sformatf("%s.step%0d", name, k), 32'(observed()), 32'(e));
            check_eq($sformatf("%s.illegal%0d", name, k), 32'(illegal), 32'(model_illegal));
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                reset = 1'b1;
                model_illegal = 1'b0;
                return;
            end
        end
        if (bad) model_illegal = 1'b1;
    endtask

    initial begin
        logic [5:0] ro, rf;
        int unsigned cls;
        reset = 1'b0; op = 6'h23; funct = 6'h00; zero = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq("rst_wen", 32'({pcen, memwrite, irwrite, regwrite}), 32'h0);
            check_eq("rst_illegal", 32'(illegal), 32'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_instr("lw",      6'h23, 6'h00, 1'b0, -1);
        run_instr("sub",     6'h00, 6'h22, 1'b0, -1);
        run_instr("beq_z1",  6'h04, 6'h00, 1'b1, -1);
        run_instr("beq_z0",  6'h04, 6'h00, 1'b0, -1);
        run_instr("bne_z0",  6'h05, 6'h00, 1'b0, -1);
        run_instr("bne_z1",  6'h05, 6'h00, 1'b1, -1);
        run_instr("badop",   6'h3f, 6'h00, 1'b0, -1);
        run_instr("addi",    6'h08, 6'h00, 1'b0, -1);
        run_instr("badfn",   6'h00, 6'h3f, 1'b0, -1);
        run_instr("j",       6'h02, 6'h00, 1'b0, -1);
        run_instr("sw_abort",6'h2b, 6'h00, 1'b0, 3);
        run_instr("sw",      6'h2b, 6'h00, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            cls = $urandom_range(0, 9);
            rf  = 6'($urandom);
            case (cls)
                0: ro = 6'h23;
                1: ro = 6'h2b;
                2: begin
                    ro = 6'h00;
                    case ($urandom_range(0, 4))
                        0: rf = 6'h20; 1: rf = 6'h22; 2: rf = 6'h24; 3: rf = 6'h25;
                        default: rf = 6'h2a;
                    endcase
                end
                3: ro = 6'h00;
                4: ro = 6'h04;
                5: ro = 6'h05;
                6: ro = 6'h08;
                7: ro = 6'h02;
                default: begin
                    ro = 6'($urandom);
                    while (op_supported(ro)) ro = 6'($urandom);
                end
            endcase
            run_instr($sformatf("rnd%0d", n), ro, rf, 1'($urandom),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
        end

        run_instr("final_j", 6'h02, 6'h00, 1'b0, -1);
        @(negedge clk);
        check_eq("final_fetch", 32'(observed()), 32'(ctl(1,0,0,1,0,0,0,0,2'b01,2'b00,3'b010)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
